// File: rtl/line_sched_pkg.sv
// Shared types for the line scheduler: coordinates, the latched line command and FSM states.
package line_sched_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        logic   color;
    } line_cmd_t;

    localparam int CMD_W = $bits(line_cmd_t);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last' wins, one-hot grant or zero.
module rr_arbiter
    import line_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_scheduler.sv
// Shares one line_drawer among N_REQ requesters and forwards its pixels to the framebuffer.
// Accept -> LOAD (1 cycle) -> DRAW (L cycles); requesters wait with valid high while busy.
module line_scheduler
    import line_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int COORD_W = line_sched_pkg::COORD_W,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*CMD_W-1:0] req_cmd,
    output logic [N_REQ-1:0]       req_done,
    output logic                   ld_reset,
    output logic [COORD_W-1:0]     ld_x0,
    output logic [COORD_W-1:0]     ld_y0,
    output logic [COORD_W-1:0]     ld_x1,
    output logic [COORD_W-1:0]     ld_y1,
    input  logic [COORD_W-1:0]     ld_x,
    input  logic [COORD_W-1:0]     ld_y,
    input  logic                   ld_complete,
    output logic [COORD_W-1:0]     pix_x,
    output logic [COORD_W-1:0]     pix_y,
    output logic                   pix_color,
    output logic                   pix_write,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

    sched_state_t     state_q;
    line_cmd_t        cmd_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    last_q;
    logic             ld_reset_q;
    logic             busy_q;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx_d;
    line_cmd_t        sel_cmd_d;
    logic             accept;
    logic             draw_act;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx_d = IW'(i);
            end
        end
    end

    assign sel_cmd_d = line_cmd_t'(req_cmd[int'(grant_idx_d)*CMD_W +: CMD_W]);
    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            owner_q    <= '0;
            last_q     <= IW'(N_REQ - 1);
            ld_reset_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_q      <= sel_cmd_d;
                        owner_q    <= grant_idx_d;
                        last_q     <= grant_idx_d;
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                        ld_reset_q <= 1'b1;
                    end
                end
                LOAD: begin
                    // ld_complete here reflects the previous line's end point
                    state_q    <= DRAW;
                    ld_reset_q <= 1'b0;
                end
                DRAW: begin
                    if (ld_complete) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        ld_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    ld_reset_q <= 1'b1;
                end
            endcase
        end
    end

    // Reset gates writes and done in the same cycle so an aborted line leaves no trace
    assign draw_act  = (state_q == DRAW) && !reset;
    assign pix_x     = ld_x;
    assign pix_y     = ld_y;
    assign pix_color = cmd_q.color;
    assign pix_write = draw_act && (ld_x < H_LIM) && (ld_y < V_LIM);

    always_comb begin
        req_done = '0;
        if (draw_act && ld_complete) begin
            req_done[owner_q] = 1'b1;
        end
    end

    assign ld_reset = ld_reset_q;
    assign busy     = busy_q;
    assign ld_x0    = cmd_q.x0;
    assign ld_y0    = cmd_q.y0;
    assign ld_x1    = cmd_q.x1;
    assign ld_y1    = cmd_q.y1;

endmodule

// File: tb/tb_line_scheduler.sv
// Scoreboard bench: stimulus pushes expected per-cycle pixel/done events, a negedge monitor pops and compares.
module tb_line_scheduler;
    import line_sched_pkg::*;

    localparam int N  = 2;
    localparam int CW = CMD_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, req_done;
    logic [N*CW-1:0] req_cmd;
    logic            ld_reset, ld_complete, pix_color, pix_write, busy;
    coord_t          ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y, pix_x, pix_y;

    logic      v   [N];
    line_cmd_t cmd [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_cmd[i*CW +: CW]    = cmd[i];
        end
    end

    line_scheduler #(.N_REQ(N), .COORD_W(COORD_W), .H_RES(640), .V_RES(480)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_done(req_done),
        .ld_reset(ld_reset), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_x(ld_x), .ld_y(ld_y), .ld_complete(ld_complete),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_write(pix_write), .busy(busy)
    );

    // Drawer stand-in: loads start point while ld_reset is high, then steps each axis toward the end point
    coord_t dx_q, dy_q;
    always @(posedge clk) begin
        if (ld_reset) begin
            dx_q <= ld_x0;
            dy_q <= ld_y0;
        end else begin
            if (dx_q < ld_x1) dx_q <= dx_q + 1'b1;
            else if (dx_q > ld_x1) dx_q <= dx_q - 1'b1;
            if (dy_q < ld_y1) dy_q <= dy_q + 1'b1;
            else if (dy_q > ld_y1) dy_q <= dy_q - 1'b1;
        end
    end
    assign ld_x        = dx_q;
    assign ld_y        = dy_q;
    assign ld_complete = (dx_q == ld_x1) && (dy_q == ld_y1);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d got=timeout expected=event", nm, cyc);
    endtask

    function automatic line_cmd_t mk(input int x0, input int y0, input int x1, input int y1, input bit c);
        line_cmd_t m;
        m.x0 = coord_t'(x0); m.y0 = coord_t'(y0);
        m.x1 = coord_t'(x1); m.y1 = coord_t'(y1);
        m.color = c;
        return m;
    endfunction

    function automatic line_cmd_t rand_cmd();
        int x0, y0;
        x0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(630, 650)) : int'($urandom_range(5, 30));
        y0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(470, 490)) : int'($urandom_range(5, 30));
        return mk(x0, y0, x0 + int'($urandom_range(0, 8)) - 4, y0 + int'($urandom_range(0, 8)) - 4,
                  1'($urandom_range(0, 1)));
    endfunction

    // Reference model: expected events per cycle, derived from accept time and line geometry
    typedef struct {
        int cy;
        int x;
        int y;
        bit col;
        bit wr;
        bit last;
        int own;
    } exp_t;
    exp_t exp_q[$];

    int        free_at = 0, last_g = N - 1;
    int        busy_lo = 1, busy_hi = 0, draw_lo = 1, draw_hi = 0, load_cyc = -1;
    bit        any_acc = 0;
    line_cmd_t load_cmd;

    task automatic push_line(input int c, input int g, input line_cmd_t m);
        int x0, y0, x1, y1, adx, ady, sx, sy, len;
        exp_t e;
        x0 = int'(m.x0); y0 = int'(m.y0); x1 = int'(m.x1); y1 = int'(m.y1);
        adx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ady = (y1 > y0) ? y1 - y0 : y0 - y1;
        sx  = (x1 > x0) ? 1 : ((x1 < x0) ? -1 : 0);
        sy  = (y1 > y0) ? 1 : ((y1 < y0) ? -1 : 0);
        len = ((adx > ady) ? adx : ady) + 1;
        for (int i = 0; i < len; i++) begin
            e.cy   = c + 2 + i;
            e.x    = x0 + sx * ((i < adx) ? i : adx);
            e.y    = y0 + sy * ((i < ady) ? i : ady);
            e.col  = m.color;
            e.wr   = (e.x < 640) && (e.y < 480);
            e.last = (i == len - 1);
            e.own  = g;
            exp_q.push_back(e);
        end
        free_at  = c + len + 2;
        busy_lo  = c + 1;  busy_hi = c + len + 1;
        draw_lo  = c + 2;  draw_hi = c + len + 1;
        load_cyc = c + 1;
        load_cmd = m;
        last_g   = g;
        any_acc  = 1;
    endtask

    always @(negedge clk) begin : monitor
        logic [N-1:0] er, ed;
        bit           ew;
        int           g;
        exp_t         e;
        if (cyc >= 1) begin
            er = '0; ed = '0; ew = 0; g = -1;
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            chk("ld_reset", ld_reset, !(cyc >= draw_lo && cyc <= draw_hi));
            if (reset) begin
                if (!any_acc) chk("reset_endpts", {ld_x0, ld_y0, ld_x1, ld_y1}, 0);
                exp_q.delete();
                free_at  = cyc + 1;
                last_g   = N - 1;
                if (busy_hi > cyc) busy_hi = cyc;
                if (draw_hi > cyc) draw_hi = cyc;
                load_cyc = -1;
            end else begin
                if (cyc == load_cyc)
                    chk("ld_endpts", {ld_x0, ld_y0, ld_x1, ld_y1},
                        {load_cmd.x0, load_cmd.y0, load_cmd.x1, load_cmd.y1});
                if (exp_q.size() > 0 && exp_q[0].cy == cyc) begin
                    e  = exp_q.pop_front();
                    ew = e.wr;
                    if (e.last) ed[e.own] = 1'b1;
                    if (ew) chk("pix_xyc", {pix_x, pix_y, pix_color},
                                {coord_t'(e.x), coord_t'(e.y), e.col});
                end
                if (cyc >= free_at) begin
                    for (int k = 1; k <= N; k++) begin
                        if (g < 0 && v[(last_g + k) % N]) g = (last_g + k) % N;
                    end
                    if (g >= 0) begin
                        er[g] = 1'b1;
                        push_line(cyc, g, cmd[g]);
                    end
                end
            end
            chk("req_ready", req_ready, er);
            chk("pix_write", pix_write, ew);
            chk("req_done", req_done, ed);
        end
    end

    // Called just after a posedge; returns just after the posedge following acceptance
    task automatic issue(input int i, input line_cmd_t m);
        v[i] = 1'b1;
        cmd[i] = m;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (req_ready[i]) break;
            if (n > 300) begin
                tmo("accept_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        v[i] = 1'b0;
        cmd[i] = rand_cmd();
    endtask

    task automatic wait_done(input int i);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (req_done[i]) break;
            if (n > 300) begin
                tmo("done_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int i);
        for (int r = 0; r < 12; r++) begin
            issue(i, rand_cmd());
            wait_done(i);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i]   = 1'b0;
            cmd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Both valid together after reset: req0 first, req1 right after req0's done
        fork
            begin issue(0, mk(10, 5, 13, 5, 1'b1)); wait_done(0); end
            begin issue(1, mk(20, 7, 18, 9, 1'b0)); wait_done(1); end
        join

        issue(0, mk(0, 478, 0, 480, 1'b0));
        wait_done(0);
        issue(0, mk(280, 0, 280, 0, 1'b1));
        wait_done(0);

        // Reset in the third DRAW cycle with req1 pending
        issue(0, mk(100, 100, 120, 100, 1'b1));
        v[1]   = 1'b1;
        cmd[1] = mk(50, 60, 52, 62, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(1, cmd[1]);
        wait_done(1);

        fork
            rand_phase(0);
            rand_phase(1);
        join

        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
